mem_req_ctrl: RTL
=================

# mem_req_ctrl

Memory-stage request controller. It is the consumer end of the EX/MEM pipeline latch: it reads the latched memory-op controls and operands and issues data-memory requests to the cache interface. While a request is outstanding it holds the pipeline with `mem_stall`, which the hazard unit inverts into the latches' `writeEN`. It captures load data for the MEM/WB latch and latches halt.

## Interface
Parameters:
- `WORD_W`, 32, data/address width (`word_t` width).
- `CNT_W`, 16, width of the stall-cycle counter.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `dMemREN_in`  in  1  EX/MEM latched load enable.
- `dMemWEN_in`  in  1  EX/MEM latched store enable.
- `Halt_in`  in  1  EX/MEM latched halt.
- `flush_in`  in  1  EX/MEM flush from the hazard unit; monitored only.
- `aluOutport_in`  in  WORD_W  effective address.
- `rdat2_in`  in  WORD_W  store data.
- `dhit`  in  1  cache completion strobe for the current request.
- `dmemload`  in  WORD_W  cache read data, valid with `dhit`.
- `dREN`, `dWEN`  out  1  request strobes to the cache.
- `dmemaddr`  out  WORD_W  request address.
- `dmemstore`  out  WORD_W  request store data.
- `mem_stall`  out  1  pipeline hold; the hazard unit drives `writeEN = !mem_stall`.
- `load_data`  out  WORD_W  captured load word.
- `load_valid`  out  1  one-cycle pulse when `load_data` updates.
- `halt`  out  1  sticky halt.
- `proto_err`  out  1  sticky protocol-violation flag.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles.

## Operation
- `op` = (`dMemREN_in` | `dMemWEN_in`) & !`halt`.
- FSM states: IDLE, WAIT, DONE. IDLE means the latch holds an instruction not yet serviced.
- IDLE:
  - If !`op`: stay in IDLE.
  - If `op` & `dhit`: go to DONE.
  - If `op` & !`dhit`: go to WAIT.
- WAIT: go to DONE on `dhit`; otherwise stay.
- DONE: go to IDLE unconditionally. The latch advances at the end of DONE.
- `dREN` = `dMemREN_in` & `op` & state∈{IDLE, WAIT}.
- `dWEN` = `dMemWEN_in` & !`dMemREN_in` & `op` & state∈{IDLE, WAIT}. Read wins if both enables are set.
- `mem_stall` = `dREN` | `dWEN`. DONE never stalls.
- `dmemaddr` = `aluOutport_in` and `dmemstore` = `rdat2_in`, passed through combinationally.
- Load capture: on an edge with `dhit` & `dREN`, `load_data` <= `dmemload` and `load_valid` <= 1. In every other cycle `load_valid` <= 0 and `load_data` holds.
- Halt: `halt` <= 1 on an edge with `Halt_in` & !`mem_stall`. It clears only on `RST`. While `halt` is set, no requests issue.
- `proto_err` <= 1 on any edge where any of the following holds:
  - `flush_in` & `mem_stall`;
  - `dMemREN_in` & `dMemWEN_in`;
  - `dhit` while `mem_stall` = 0.
- `stall_cnt` increments on every edge with `mem_stall` = 1 and saturates at all-ones.

## Timing
- Combinational paths: `dREN`, `dWEN` and `mem_stall` depend on current state and latch inputs only; `dmemaddr` and `dmemstore` pass through from the latch operands. There is no path from `dhit` to any output.
- Access with `dhit` in the same cycle: 1 stall cycle, then 1 DONE cycle, so 2 cycles total.
- Access with N wait cycles: N+1 stall cycles, then DONE.
- Back-to-back memory ops: the second op's request starts in the IDLE cycle right after DONE.
- `load_valid` is high during the DONE cycle; `load_data` is valid from DONE onward.
- Reset while `RST`=1 (including mid-WAIT): state <= IDLE, `load_data` <= 0, `load_valid` <= 0, `halt` <= 0, `proto_err` <= 0, `stall_cnt` <= 0.
- Outputs during the `RST`=1 cycle: `dREN`, `dWEN` and `mem_stall` are forced to 0. An abandoned request is not replayed.
- `Halt_in` with a memory op in the same latch entry: the access completes first. `halt` sets on the DONE edge (stall is 0 there).

## Structure
- `cpu_types_pkg` holds the shared items:
  - `word_t`;
  - the FSM state enum `memctl_state_t` {IDLE, WAIT, DONE};
  - the stall-counter width constant.
- Sub-modules: none required. The saturating counter may be split out as `sat_counter`.
- The interface is bundled as `mem_req_ctrl_if`, with modports `ctrl` and `tb`.

## Test plan
- Load, hit in the same cycle: `dMemREN_in`=1, `aluOutport_in`=0x0000_0040, `dhit`=1, `dmemload`=0xDEAD_BEEF. Required response:
  - cycle 0: `dREN`=1, `mem_stall`=1;
  - cycle 1: DONE, `load_valid`=1, `load_data`=0xDEAD_BEEF, `mem_stall`=0;
  - `stall_cnt`=1.
- Store, 3 wait cycles: `dMemWEN_in`=1, `rdat2_in`=0x1234_5678, `dhit` on the 4th cycle. Required response:
  - `dWEN`=1 and `dmemstore`=0x1234_5678 for 4 cycles;
  - `load_valid` stays 0;
  - `stall_cnt`=4.
- Reset mid-WAIT: assert `RST` in the 2nd wait cycle. Required response: next cycle state=IDLE, all outputs at reset values, `stall_cnt`=0.
- Halt: `Halt_in`=1 with no op. Required response:
  - `halt`=1 after 1 edge;
  - a later `dMemREN_in`=1 produces `dREN`=0;
  - `halt` stays set until `RST`.
- Protocol errors: `flush_in`=1 during WAIT sets `proto_err`=1; REN=WEN=1 gives `dREN`=1, `dWEN`=0 and sets `proto_err`.
- Counter saturation: with `CNT_W`=4, hold a load in WAIT for 20 cycles. Required response: `stall_cnt`=0xF, no wrap.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory stage: word type, request FSM states and
// default widths used by the request controller and its counter.
package cpu_types_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_CNT_W  = 16;

    typedef logic [DEF_WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memctl_state_t;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Signal bundle between the EX/MEM latch, the cache port and the request
// controller, with views for the controller and for a bench.
interface mem_req_ctrl_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
)(
    input logic CLK
);
    logic              RST;
    logic              dMemREN_in;
    logic              dMemWEN_in;
    logic              Halt_in;
    logic              flush_in;
    logic [WORD_W-1:0] aluOutport_in;
    logic [WORD_W-1:0] rdat2_in;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              mem_stall;
    logic [WORD_W-1:0] load_data;
    logic              load_valid;
    logic              halt;
    logic              proto_err;
    logic [CNT_W-1:0]  stall_cnt;

    modport ctrl (
        input  CLK, RST, dMemREN_in, dMemWEN_in, Halt_in, flush_in,
               aluOutport_in, rdat2_in, dhit, dmemload,
        output dREN, dWEN, dmemaddr, dmemstore, mem_stall, load_data,
               load_valid, halt, proto_err, stall_cnt
    );

    modport tb (
        input  CLK, dREN, dWEN, dmemaddr, dmemstore, mem_stall, load_data,
               load_valid, halt, proto_err, stall_cnt,
        output RST, dMemREN_in, dMemWEN_in, Halt_in, flush_in,
               aluOutport_in, rdat2_in, dhit, dmemload
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
)(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_req_ctrl.sv
// MEM-stage request controller: issues cache requests for the EX/MEM latch
// entry, holds the pipeline until dhit, captures load data and latches halt.
module mem_req_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              dMemREN_in,
    input  logic              dMemWEN_in,
    input  logic              Halt_in,
    input  logic              flush_in,
    input  logic [WORD_W-1:0] aluOutport_in,
    input  logic [WORD_W-1:0] rdat2_in,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] load_data,
    output logic              load_valid,
    output logic              halt,
    output logic              proto_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    memctl_state_t     state_q, state_d;
    logic [WORD_W-1:0] load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              halt_q, halt_d;
    logic              perr_q, perr_d;
    logic              op;
    logic              req_phase;

    assign op        = (dMemREN_in | dMemWEN_in) & ~halt_q;
    // Requests are suppressed during the reset cycle so an abandoned access never leaks out.
    assign req_phase = ((state_q == IDLE) || (state_q == WAIT)) && !RST;

    assign dREN      = dMemREN_in & op & req_phase;
    assign dWEN      = dMemWEN_in & ~dMemREN_in & op & req_phase;
    assign mem_stall = dREN | dWEN;
    assign dmemaddr  = aluOutport_in;
    assign dmemstore = rdat2_in;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op) state_d = dhit ? DONE : WAIT;
            WAIT:    if (dhit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        if (dhit && dREN) begin
            load_data_d  = dmemload;
            load_valid_d = 1'b1;
        end
    end

    assign halt_d = halt_q | (Halt_in & ~mem_stall);
    assign perr_d = perr_q
                  | (flush_in & mem_stall)
                  | (dMemREN_in & dMemWEN_in)
                  | (dhit & ~mem_stall);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            halt_q       <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            halt_q       <= halt_d;
            perr_q       <= perr_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .inc_i (mem_stall),
        .cnt_o (stall_cnt)
    );

    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign halt       = halt_q;
    assign proto_err  = perr_q;

endmodule
